instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 32: PC and memory address width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum cycles in REQ before abort; used only when FETCH_TIMEOUT_EN is defined.
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 PCwrite  in  1  from control unit; load PC from PCnext.
REQ-007 PCnext  in  ADDR_W  next PC (ALU result).
REQ-008 ImemRead  in  1  from control unit; start one instruction fetch.
REQ-009 LoadIr  in  1  from control unit; move fetched word into IR.
REQ-010 ImemReq  out  1  memory read request.
REQ-011 ImemAddr  out  ADDR_W  memory read address.
REQ-012 ImemAck  in  1  memory data valid this cycle.
REQ-013 ImemData  in  32  memory read data.
REQ-014 Pc  out  ADDR_W  current PC register.
REQ-015 Instr  out  32  instruction register (IR).
REQ-016 IrValid  out  1  IR holds a fetched word.
REQ-017 Busy  out  1  fetch outstanding; control unit stalls.
REQ-018 FetchErr  out  1  sticky error flag.
REQ-019 Opcode 7, Rd 5, Funct3 3, Rs1 5, Rs2 5, Funct7 7  out  combinational fields of Instr: [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].

Function
REQ-020 States: IDLE, REQ, BUF.
REQ-021 IDLE + ImemRead -> REQ next cycle; ImemRead in REQ or BUF is ignored.
REQ-022 In REQ: ImemReq=1, ImemAddr=Pc; both held stable until the ImemAck cycle; Busy=1.
REQ-023 REQ + ImemAck without LoadIr: capture ImemData into the fetch buffer; -> BUF; ImemReq=0 from the next cycle.
REQ-024 REQ + ImemAck + LoadIr in the same cycle: bypass; Instr<=ImemData, IrValid<=1; -> IDLE.
REQ-025 BUF + LoadIr: Instr<=buffer, IrValid<=1; -> IDLE. BUF holds indefinitely without LoadIr.
REQ-026 LoadIr in IDLE, or in REQ without ImemAck: ignored; Instr and IrValid unchanged.
REQ-027 PCwrite in IDLE or BUF: Pc<=PCnext when PCnext[1:0]==0.
- Misaligned PCnext: Pc unchanged, FetchErr<=1.
REQ-028 PCwrite in REQ: ignored, so ImemAddr stays stable.
REQ-029 PCwrite + ImemRead in IDLE in the same cycle: Pc updates; the request issues the new Pc.
REQ-030 Fetch latency: ImemRead to ImemReq is 1 cycle; ImemAck to Instr update (with LoadIr) is 1 cycle.
REQ-031 FetchErr is cleared only by reset.
REQ-032 Busy=1 only in REQ; Busy=0 in IDLE and BUF.

Reset
REQ-033 Reset low forces, asynchronously and in any state including mid-REQ:
- state IDLE; ImemReq=0; Pc=RESET_PC;
- Instr=32'h0000_0013 (NOP); buffer=0; IrValid=0; FetchErr=0; Busy=0.
REQ-034 Fetch resumes only on the first ImemRead after Reset deasserts; an ImemAck arriving after reset is ignored.

Configuration
REQ-035 Macro FETCH_TIMEOUT_EN defined: a counter clears on REQ entry and increments each REQ cycle.
- At TIMEOUT_CYC without ImemAck: FetchErr<=1, ImemReq drops, state -> IDLE, IR unchanged.
REQ-036 Macro undefined: no counter; REQ waits indefinitely for ImemAck.

Structure
REQ-037 Package fetch_pkg holds the state enum, the NOP constant, and the default RESET_PC.
REQ-038 Sub-module ir_fields: purely combinational field extraction from Instr.
REQ-039 FSM, PC, buffer, IR and the timeout counter live in instr_fetch.

Verification
REQ-040 Reset low mid-REQ -> ImemReq=0 immediately; Pc=RESET_PC; Instr=0x00000013; IrValid=0.
REQ-041 ImemRead; ImemAck 3 cycles later with 0x00500093; LoadIr 2 cycles after that -> Instr=0x00500093, Opcode=0x13, Rd=1, Rs1=0.
REQ-042 ImemAck and LoadIr in the same cycle with 0x002081B3 -> Instr updated the next cycle, Funct7=0, Rs2=2; state IDLE.
REQ-043 PCwrite with PCnext=0x104 during REQ -> Pc unchanged; PCwrite with 0x104 in BUF -> Pc=0x104; PCnext=0x106 -> FetchErr=1, Pc unchanged.
REQ-044 FETCH_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ImemAck -> FetchErr=1 and ImemReq=0 after 4 REQ cycles; with the macro undefined, ImemReq is still 1 after 100 cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, the NOP reset value of the IR and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUF  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: a level request with address, answered by a
// single-cycle acknowledge carrying the read word.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              ImemReq;
    logic [ADDR_W-1:0] ImemAddr;
    logic              ImemAck;
    logic [31:0]       ImemData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemData
    );
endinterface

// File: rtl/ir_fields.sv
// Purely combinational decode of the RV32 base-format fields held in the IR.
module ir_fields (
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: PC register, one-word fetch buffer and IR.
// Optional REQ watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PCwrite,
    input  logic [ADDR_W-1:0] PCnext,
    input  logic              ImemRead,
    input  logic              LoadIr,
    instr_fetch_if.master     imem,
    output logic [ADDR_W-1:0] Pc,
    output logic [31:0]       Instr,
    output logic              IrValid,
    output logic              Busy,
    output logic              FetchErr,
    output logic [6:0]        Opcode,
    output logic [4:0]        Rd,
    output logic [2:0]        Funct3,
    output logic [4:0]        Rs1,
    output logic [4:0]        Rs2,
    output logic [6:0]        Funct7
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       instr_q, instr_d;
    logic              ir_valid_q, ir_valid_d;
    logic              err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        instr_d    = instr_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        // PC may only move while no request is on the bus, keeping ImemAddr stable
        if (PCwrite && (state_q != ST_REQ)) begin
            if (PCnext[1:0] == 2'b00) begin
                pc_d = PCnext;
            end else begin
                err_d = 1'b1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (ImemRead) begin
                    state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (imem.ImemAck) begin
                    if (LoadIr) begin
                        instr_d    = imem.ImemData;
                        ir_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        buf_d   = imem.ImemData;
                        state_d = ST_BUF;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_BUF: begin
                if (LoadIr) begin
                    instr_d    = buf_q;
                    ir_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            instr_q    <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign imem.ImemReq  = (state_q == ST_REQ);
    assign imem.ImemAddr = pc_q;
    assign Busy          = (state_q == ST_REQ);
    assign Pc            = pc_q;
    assign Instr         = instr_q;
    assign IrValid       = ir_valid_q;
    assign FetchErr      = err_q;

    ir_fields u_fields (
        .instr  (instr_q),
        .opcode (Opcode),
        .rd     (Rd),
        .funct3 (Funct3),
        .rs1    (Rs1),
        .rs2    (Rs2),
        .funct7 (Funct7)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch plus hand sequences for
// asynchronous reset and the REQ timeout / no-timeout behaviour.
module tb_instr_fetch;
    import fetch_pkg::*;

`ifdef FETCH_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    logic        Clk;
    logic        Reset;
    logic        PCwrite;
    logic [31:0] PCnext;
    logic        ImemRead;
    logic        LoadIr;
    logic [31:0] Pc;
    logic [31:0] Instr;
    logic        IrValid;
    logic        Busy;
    logic        FetchErr;
    logic [6:0]  Opcode;
    logic [4:0]  Rd;
    logic [2:0]  Funct3;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [6:0]  Funct7;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_if #(.ADDR_W(32)) imem ();

    instr_fetch #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PCwrite  (PCwrite),
        .PCnext   (PCnext),
        .ImemRead (ImemRead),
        .LoadIr   (LoadIr),
        .imem     (imem),
        .Pc       (Pc),
        .Instr    (Instr),
        .IrValid  (IrValid),
        .Busy     (Busy),
        .FetchErr (FetchErr),
        .Opcode   (Opcode),
        .Rd       (Rd),
        .Funct3   (Funct3),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Funct7   (Funct7)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        pcw;
        logic [31:0] pcn;
        logic        rd;
        logic        ld;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_val;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic pcw, logic [31:0] pcn, logic rd, logic ld,
                                logic ack, logic [31:0] dat, logic e_req,
                                logic [31:0] e_pc, logic [31:0] e_ins,
                                logic e_val, logic e_err);
        vec_t v;
        v.pcw = pcw; v.pcn = pcn; v.rd = rd; v.ld = ld; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_pc = e_pc; v.e_ins = e_ins; v.e_val = e_val; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCwrite = 1'b0; PCnext = '0; ImemRead = 1'b0; LoadIr = 1'b0;
        imem.ImemAck = 1'b0; imem.ImemData = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              pcw pcn          rd ld ack dat            req pc        instr          val err
        vecs[0]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,   NOP_INSTR,     0, 0);
        vecs[1]  = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,   NOP_INSTR,     0, 0);
        vecs[2]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h0,   NOP_INSTR,     0, 0);
        vecs[3]  = mk(0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h0,   NOP_INSTR,     0, 0);
        vecs[4]  = mk(1, 32'h104,      0, 0, 0, 32'h0,        1, 32'h0,   NOP_INSTR,     0, 0);
        vecs[5]  = mk(0, 32'h0,        0, 0, 1, 32'h00500093, 0, 32'h0,   NOP_INSTR,     0, 0);
        vecs[6]  = mk(1, 32'h104,      0, 0, 0, 32'h0,        0, 32'h104, NOP_INSTR,     0, 0);
        vecs[7]  = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h104, 32'h00500093,  1, 0);
        vecs[8]  = mk(1, 32'h106,      0, 0, 0, 32'h0,        0, 32'h104, 32'h00500093,  1, 1);
        vecs[9]  = mk(1, 32'h200,      1, 0, 0, 32'h0,        1, 32'h200, 32'h00500093,  1, 1);
        vecs[10] = mk(0, 32'h0,        0, 1, 1, 32'h002081B3, 0, 32'h200, 32'h002081B3,  1, 1);
        vecs[11] = mk(0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h200, 32'h002081B3,  1, 1);
        vecs[12] = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h200, 32'h002081B3,  1, 1);
        vecs[13] = mk(0, 32'h0,        0, 0, 1, 32'h11111111, 0, 32'h200, 32'h002081B3,  1, 1);
        vecs[14] = mk(0, 32'h0,        1, 0, 1, 32'h22222222, 0, 32'h200, 32'h002081B3,  1, 1);
        vecs[15] = mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h200, 32'h11111111,  1, 1);

        idle_inputs();
        Reset = 1'b0;
        #12;
        chk("rst.req",   imem.ImemReq, 32'd0);
        chk("rst.pc",    Pc,           32'h0);
        chk("rst.instr", Instr,        NOP_INSTR);
        chk("rst.valid", IrValid,      32'd0);
        chk("rst.err",   FetchErr,     32'd0);
        chk("rst.busy",  Busy,         32'd0);
        tick();
        Reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            PCwrite      = vecs[i].pcw;
            PCnext       = vecs[i].pcn;
            ImemRead     = vecs[i].rd;
            LoadIr       = vecs[i].ld;
            imem.ImemAck = vecs[i].ack;
            imem.ImemData = vecs[i].dat;
            tick();
            $display("vec %0d: req=%0b pc=0x%08h instr=0x%08h valid=%0b err=%0b",
                     i, imem.ImemReq, Pc, Instr, IrValid, FetchErr);
            chk($sformatf("vec%0d.req", i),   imem.ImemReq, 32'(vecs[i].e_req));
            chk($sformatf("vec%0d.busy", i),  Busy,         32'(vecs[i].e_req));
            chk($sformatf("vec%0d.pc", i),    Pc,           vecs[i].e_pc);
            chk($sformatf("vec%0d.instr", i), Instr,        vecs[i].e_ins);
            chk($sformatf("vec%0d.valid", i), IrValid,      32'(vecs[i].e_val));
            chk($sformatf("vec%0d.err", i),   FetchErr,     32'(vecs[i].e_err));
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d.addr", i), imem.ImemAddr, vecs[i].e_pc);
            end
            if (i == 7) begin
                chk("addi.opcode", 32'(Opcode), 32'h13);
                chk("addi.rd",     32'(Rd),     32'd1);
                chk("addi.rs1",    32'(Rs1),    32'd0);
                chk("addi.funct3", 32'(Funct3), 32'd0);
            end
            if (i == 10) begin
                chk("add.funct7", 32'(Funct7), 32'd0);
                chk("add.rs2",    32'(Rs2),    32'd2);
                chk("add.rs1",    32'(Rs1),    32'd1);
                chk("add.rd",     32'(Rd),     32'd3);
                chk("add.opcode", 32'(Opcode), 32'h33);
            end
        end
        idle_inputs();

        // Asynchronous reset while a request is outstanding
        ImemRead = 1'b1;
        tick();
        ImemRead = 1'b0;
        chk("midreq.req_before", imem.ImemReq, 32'd1);
        #3;
        Reset = 1'b0;
        #1;
        $display("async reset: req=%0b pc=0x%08h instr=0x%08h valid=%0b",
                 imem.ImemReq, Pc, Instr, IrValid);
        chk("midreq.req",   imem.ImemReq, 32'd0);
        chk("midreq.busy",  Busy,         32'd0);
        chk("midreq.pc",    Pc,           32'h0);
        chk("midreq.instr", Instr,        NOP_INSTR);
        chk("midreq.valid", IrValid,      32'd0);
        chk("midreq.err",   FetchErr,     32'd0);
        tick();
        Reset = 1'b1;

        // Stray ack after reset must not start or complete a fetch
        imem.ImemAck  = 1'b1;
        imem.ImemData = 32'h33333333;
        LoadIr        = 1'b1;
        tick();
        idle_inputs();
        $display("post-reset ack: req=%0b instr=0x%08h", imem.ImemReq, Instr);
        chk("postrst.req",   imem.ImemReq, 32'd0);
        chk("postrst.instr", Instr,        NOP_INSTR);
        chk("postrst.valid", IrValid,      32'd0);

        // Request with no acknowledge
        ImemRead = 1'b1;
        tick();
        ImemRead = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int c = 0; c < TB_TO - 1; c++) tick();
        chk("to.req_last", imem.ImemReq, 32'd1);
        tick();
        $display("timeout: req=%0b err=%0b", imem.ImemReq, FetchErr);
        chk("to.req",   imem.ImemReq, 32'd0);
        chk("to.busy",  Busy,         32'd0);
        chk("to.err",   FetchErr,     32'd1);
        chk("to.instr", Instr,        NOP_INSTR);
        chk("to.valid", IrValid,      32'd0);
`else
        for (int c = 0; c < 100; c++) tick();
        $display("no timeout: req=%0b err=%0b", imem.ImemReq, FetchErr);
        chk("noto.req",  imem.ImemReq, 32'd1);
        chk("noto.busy", Busy,         32'd1);
        chk("noto.err",  FetchErr,     32'd0);
        chk("noto.addr", imem.ImemAddr, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
